floor_request_scheduler: RTL and testbench

Call-button front end and dispatcher for the elevator datapath. Captures floor-call button presses into a pending-request register, picks the next floor to serve using a SCAN (continue-in-direction) policy, and drives the 4-bit requested-floor input of the elevator motion state machine. On arrival it clears the served call and holds the door open for a fixed dwell before dispatching again.

---
 rtl/floor_request_scheduler.sv | 159 +++++++++++++++
 tb/tb_floor_request_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// Elevator call-button front end and SCAN dispatcher: latches floor calls, picks the
// next floor in the current travel direction, and holds the door for a fixed dwell.
module floor_request_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  clear_all,
    input  logic [3:0]            current_floor,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;
    state_t state, state_nx;

    logic [NUM_FLOORS-1:0] sync1, sync2, sync3, rise, here_mask, clr_mask;
    logic [CW-1:0]         dwell_cnt;
    logic [3:0]            target_q;
    logic [3:0]            up_sel, dn_sel, sel_floor;
    logic                  up_found, dn_found, sel_found, sel_dir;
    logic                  here, any_pending, arrive, dwell_reload;

    // Two-flop synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= call_btn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    // Out-of-range current_floor yields an all-zero mask, so nothing matches or clears
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++)
            here_mask[i] = (current_floor == 4'(i));
    end

    assign here         = |(pending & here_mask);
    assign any_pending  = |pending;
    assign arrive       = (current_floor == target_q);
    assign dwell_reload = (state == DWELL) && |(rise & here_mask);

    // Nearest pending floor strictly above / strictly below current_floor
    always_comb begin
        up_found = 1'b0;
        up_sel   = '0;
        dn_found = 1'b0;
        dn_sel   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (4'(i) > current_floor)) begin
                up_found = 1'b1;
                up_sel   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (4'(i) < current_floor)) begin
                dn_found = 1'b1;
                dn_sel   = 4'(i);
            end
        end
    end

    always_comb begin
        sel_found = up_found || dn_found;
        if (dir_up) begin
            sel_floor = up_found ? up_sel : dn_sel;
            sel_dir   = up_found;
        end else begin
            sel_floor = dn_found ? dn_sel : up_sel;
            sel_dir   = !dn_found;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear_all) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (here)             state_nx = DWELL;
                         else if (any_pending) state_nx = SERVE;
                SERVE:   if (arrive)           state_nx = DWELL;
                DWELL:   if (!dwell_reload && (dwell_cnt == '0)) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // The call at the door is swallowed for the whole dwell, including the entry cycle
    assign clr_mask = ((state == DWELL) || (state_nx == DWELL)) ? here_mask : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            target_q  <= '0;
            dir_up    <= 1'b1;
            dwell_cnt <= '0;
        end else if (clear_all) begin
            pending   <= '0;
            target_q  <= current_floor;
            dwell_cnt <= '0;
        end else begin
            pending <= (pending | rise) & ~clr_mask;
            case (state)
                IDLE: begin
                    if (here) begin
                        target_q  <= current_floor;
                        dwell_cnt <= DWELL_LOAD;
                    end else if (any_pending) begin
                        target_q <= sel_floor;
                        dir_up   <= sel_dir;
                    end else begin
                        target_q <= current_floor;
                    end
                end
                SERVE: begin
                    if (arrive) begin
                        dwell_cnt <= DWELL_LOAD;
                    end else if (sel_found) begin
                        target_q <= sel_floor;
                        dir_up   <= sel_dir;
                    end
                end
                DWELL: begin
                    target_q <= current_floor;
                    if (dwell_reload)          dwell_cnt <= DWELL_LOAD;
                    else if (dwell_cnt != '0)  dwell_cnt <= dwell_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        target_floor = target_q;
        target_valid = (state == SERVE);
        door_open    = (state == DWELL);
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level reference model.
module tb_floor_request_scheduler;
    localparam int NF = 10;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_btn = '0;
    logic          clear_all = 1'b0;
    logic [3:0]    current_floor = '0;
    logic [3:0]    target_floor;
    logic          target_valid, door_open, dir_up;
    logic [NF-1:0] pending;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    floor_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .call_btn(call_btn), .clear_all(clear_all),
        .current_floor(current_floor), .target_floor(target_floor),
        .target_valid(target_valid), .door_open(door_open), .dir_up(dir_up),
        .pending(pending)
    );

    // Reference model: mode 0 idle, 1 travelling, 2 door open; m_left = door cycles remaining
    logic [NF-1:0] m_pend, h0, h1, h2;
    int            m_mode, m_tgt, m_left;
    logic          m_dir;

    task automatic model_reset();
        m_pend = '0; h0 = '0; h1 = '0; h2 = '0;
        m_mode = 0; m_tgt = 0; m_left = 0; m_dir = 1'b1;
    endtask

    function automatic int nearest(input logic [NF-1:0] p, input int cur, input int sgn);
        for (int d = 1; d < 16; d++) begin
            int f;
            f = cur + sgn * d;
            if (f >= 0 && f < NF && p[f]) return f;
        end
        return -1;
    endfunction

    task automatic model_pick(input int cur);
        int a, b;
        a = nearest(m_pend, cur, m_dir ? 1 : -1);
        b = nearest(m_pend, cur, m_dir ? -1 : 1);
        if (a >= 0) m_tgt = a;
        else if (b >= 0) begin
            m_tgt = b;
            m_dir = ~m_dir;
        end
    endtask

    task automatic model_step();
        int cur, nmode;
        logic [NF-1:0] r;
        logic here_r, rise_here;
        cur = int'(current_floor);
        // a button level seen two edges ago but not three edges ago is a fresh press
        r = h1 & ~h0;
        h0 = h1; h1 = h2; h2 = call_btn;
        here_r    = (cur < NF) && m_pend[cur];
        rise_here = (cur < NF) && r[cur];
        nmode = m_mode;
        if (clear_all) begin
            m_pend = '0; m_mode = 0; m_tgt = cur;
        end else begin
            case (m_mode)
                0: if (here_r) begin nmode = 2; m_tgt = cur; m_left = D; end
                   else if (m_pend != '0) begin model_pick(cur); nmode = 1; end
                   else m_tgt = cur;
                1: if (cur == m_tgt) begin nmode = 2; m_left = D; end
                   else model_pick(cur);
                default: begin
                    m_tgt = cur;
                    if (rise_here) m_left = D;
                    else if (m_left == 1) nmode = 0;
                    else m_left--;
                end
            endcase
            m_pend = m_pend | r;
            if ((m_mode == 2 || nmode == 2) && cur < NF) m_pend[cur] = 1'b0;
            m_mode = nmode;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; call_btn = '0; clear_all = 1'b0; current_floor = '0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({target_floor, target_valid, door_open, dir_up, pending} !== {4'd0, 1'b0, 1'b0, 1'b1, {NF{1'b0}}})
            $display("FAIL reset_values: got tf=%0d tv=%b do=%b up=%b p=%b want 0/0/0/1/0",
                     target_floor, target_valid, door_open, dir_up, pending);
        else n_pass++;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++;
            if (target_floor !== 4'd0 || target_valid !== 1'b0 || door_open !== 1'b0 || pending !== '0)
                $display("FAIL idle_quiet: got tf=%0d tv=%b do=%b p=%b want all zero",
                         target_floor, target_valid, door_open, pending);
            else n_pass++;
        end
    endtask

    task automatic test_single_call();
        logic [NF-1:0] exp_p;
        int n;
        apply_reset();
        exp_p = '0; exp_p[5] = 1'b1;
        call_btn[5] = 1'b1;
        tick(); tick();
        n_chk++;
        if (pending !== '0) $display("FAIL early_pending: got %b want 0", pending);
        else n_pass++;
        tick();
        n_chk++;
        if (pending !== exp_p) $display("FAIL pending_latency: got %b want %b", pending, exp_p);
        else n_pass++;
        tick();
        n_chk++;
        if (target_valid !== 1'b1 || target_floor !== 4'd5)
            $display("FAIL dispatch: got tv=%b tf=%0d want 1/5", target_valid, target_floor);
        else n_pass++;
        call_btn[5] = 1'b0;
        current_floor = 4'd5;
        tick();
        n_chk++;
        if (door_open !== 1'b1 || pending !== '0 || target_valid !== 1'b0)
            $display("FAIL arrive: got do=%b p=%b tv=%b want 1/0/0", door_open, pending, target_valid);
        else n_pass++;
        n = 1;
        while (door_open && n < 100) begin
            tick();
            if (door_open) n++;
        end
        n_chk++;
        if (n !== D) $display("FAIL dwell_length: got %0d want %0d", n, D);
        else n_pass++;
        n_chk++;
        if (target_floor !== 4'd5 || target_valid !== 1'b0 || door_open !== 1'b0)
            $display("FAIL after_dwell: got tf=%0d tv=%b do=%b want 5/0/0", target_floor, target_valid, door_open);
        else n_pass++;
    endtask

    task automatic test_scan();
        int served[$];
        int exp_order[4];
        int cycles, got;
        logic was_open, pressed3;
        exp_order = '{4, 7, 3, 1};
        apply_reset();
        current_floor = 4'd2;
        call_btn[7] = 1'b1; call_btn[4] = 1'b1; call_btn[1] = 1'b1;
        tick();
        call_btn = '0;
        was_open = 1'b0; pressed3 = 1'b0; cycles = 0;
        while (served.size() < 4 && cycles < 1000) begin
            tick();
            cycles++;
            if (door_open && !was_open) begin
                served.push_back(int'(current_floor));
                if (served.size() == 3) begin
                    n_chk++;
                    if (dir_up !== 1'b0) $display("FAIL scan_reverse: got dir_up=%b want 0", dir_up);
                    else n_pass++;
                end
            end
            was_open = door_open;
            call_btn = '0;
            if (!pressed3 && current_floor == 4'd5 && target_valid && target_floor == 4'd7) begin
                call_btn[3] = 1'b1;
                pressed3 = 1'b1;
            end
            if (target_valid && current_floor != target_floor)
                current_floor = (current_floor < target_floor) ? current_floor + 4'd1 : current_floor - 4'd1;
        end
        for (int k = 0; k < 4; k++) begin
            got = (served.size() > k) ? served[k] : -1;
            n_chk++;
            if (got != exp_order[k]) $display("FAIL scan_order[%0d]: got %0d want %0d", k, got, exp_order[k]);
            else n_pass++;
        end
    endtask

    task automatic test_retarget();
        apply_reset();
        current_floor = 4'd2;
        call_btn[8] = 1'b1;
        tick();
        call_btn = '0;
        repeat (3) tick();
        n_chk++;
        if (target_valid !== 1'b1 || target_floor !== 4'd8)
            $display("FAIL retarget_initial: got tv=%b tf=%0d want 1/8", target_valid, target_floor);
        else n_pass++;
        current_floor = 4'd3;
        call_btn[5] = 1'b1;
        tick();
        call_btn = '0;
        repeat (2) tick();
        n_chk++;
        if (target_floor !== 4'd8) $display("FAIL retarget_early: got %0d want 8", target_floor);
        else n_pass++;
        tick();
        n_chk++;
        if (target_valid !== 1'b1 || target_floor !== 4'd5 || dir_up !== 1'b1)
            $display("FAIL retarget: got tv=%b tf=%0d up=%b want 1/5/1", target_valid, target_floor, dir_up);
        else n_pass++;
    endtask

    task automatic test_dwell_extend();
        int n, total;
        logic bad;
        apply_reset();
        current_floor = 4'd3;
        call_btn[3] = 1'b1;
        tick(); tick();
        call_btn = '0;
        n = 0;
        while (!door_open && n < 20) begin
            tick();
            n++;
        end
        n_chk++;
        if (door_open !== 1'b1) $display("FAIL dwell_start: got door_open=%b want 1", door_open);
        else n_pass++;
        total = 1;
        while (door_open && total < 200) begin
            if (total == 9) call_btn[3] = 1'b1;
            tick();
            if (door_open) total++;
        end
        n_chk++;
        if (total != 27) $display("FAIL dwell_extend: got %0d cycles want 27", total);
        else n_pass++;
        bad = 1'b0;
        repeat (80) begin
            tick();
            if (door_open || pending != '0 || target_valid) bad = 1'b1;
        end
        n_chk++;
        if (bad !== 1'b0) $display("FAIL held_single_request: got re-dispatch=%b want 0", bad);
        else n_pass++;
        call_btn = '0;
        repeat (4) tick();
    endtask

    task automatic test_clear_all();
        logic [NF-1:0] exp_p;
        int n;
        apply_reset();
        exp_p = '0; exp_p[6] = 1'b1; exp_p[9] = 1'b1;
        call_btn = exp_p;
        tick();
        call_btn = '0;
        repeat (3) tick();
        n_chk++;
        if (target_valid !== 1'b1 || target_floor !== 4'd6 || pending !== exp_p)
            $display("FAIL clear_setup: got tv=%b tf=%0d p=%b want 1/6/%b", target_valid, target_floor, pending, exp_p);
        else n_pass++;
        current_floor = 4'd1;
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        n_chk++;
        if (pending !== '0 || target_valid !== 1'b0 || target_floor !== 4'd1 || door_open !== 1'b0 || dir_up !== 1'b1)
            $display("FAIL clear_all: got p=%b tv=%b tf=%0d do=%b up=%b want 0/0/1/0/1",
                     pending, target_valid, target_floor, door_open, dir_up);
        else n_pass++;
        current_floor = 4'd0;
        call_btn[0] = 1'b1;
        tick();
        call_btn = '0;
        n = 0;
        while (!door_open && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        n_chk++;
        if (door_open !== 1'b1) $display("FAIL reset_setup: got door_open=%b want 1", door_open);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (door_open !== 1'b0 || pending !== '0 || target_valid !== 1'b0 || target_floor !== 4'd0 || dir_up !== 1'b1)
            $display("FAIL async_reset: got do=%b p=%b tv=%b tf=%0d up=%b want 0/0/0/0/1",
                     door_open, pending, target_valid, target_floor, dir_up);
        else n_pass++;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_random();
        int r;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            n_chk++;
            if ({target_floor, target_valid, door_open, dir_up, pending} !==
                {4'(m_tgt), (m_mode == 1), (m_mode == 2), m_dir, m_pend})
                $display("FAIL random_cycle %0d: got tf=%0d tv=%b do=%b up=%b p=%b want tf=%0d mode=%0d up=%b p=%b",
                         c, target_floor, target_valid, door_open, dir_up, pending, m_tgt, m_mode, m_dir, m_pend);
            else n_pass++;
            if ($urandom_range(9) == 0) call_btn[$urandom_range(NF - 1)] ^= 1'b1;
            clear_all = ($urandom_range(99) == 0);
            r = int'($urandom_range(99));
            if (r < 2)
                current_floor = 4'($urandom_range(15));
            else if (r < 50 && target_valid && current_floor != target_floor)
                current_floor = (current_floor < target_floor) ? current_floor + 4'd1 : current_floor - 4'd1;
        end
        clear_all = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_scan();
        test_retarget();
        test_dwell_extend();
        test_clear_all();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
